muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width; SHALL be even and >= 4.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset; asynchronous and active-high.
REQ-004 start_i  input  1  request; accepted only in IDLE.
REQ-005 op_i  input  2  operation: 00 mult (signed), 01 multu, 10 div (signed), 11 divu; sampled with start_i.
REQ-006 opa_i  input  WIDTH  multiplicand / dividend; sampled with start_i.
REQ-007 opb_i  input  WIDTH  multiplier / divisor; sampled with start_i.
REQ-008 annul_i  input  1  abort of the in-flight operation.
REQ-009 busy_o  output  1  high in every state except IDLE.
REQ-010 ready_o  output  1  one-cycle pulse; hi_o/lo_o valid.
REQ-011 hi_o  output  WIDTH  product high half / remainder.
REQ-012 lo_o  output  WIDTH  product low half / quotient.
REQ-013 divzero_o  output  1  high with ready_o when the divisor was zero; low otherwise.

Function
REQ-014 FSM states SHALL be IDLE, MUL, DIV, FIX, DONE.
REQ-015 IDLE with start_i=1 and annul_i=0: operands, op and count=0 SHALL be captured; next state MUL (op 0x) or DIV (op 1x).
REQ-016 Signed ops SHALL iterate on operand magnitudes; record result sign (mult: signa^signb; quotient: signa^signb; remainder: signa).
REQ-017 MUL: one shift-add step per cycle; DIV: one restoring shift-subtract step per cycle; each SHALL run exactly WIDTH cycles, then go to FIX.
REQ-018 FIX SHALL apply the sign correction (two's complement of the 2*WIDTH product, or of quotient and remainder independently), then go to DONE.
REQ-019 hi_o/lo_o SHALL be registered, updated only on the edge entering DONE, and held until the next such edge.
REQ-020 DONE SHALL assert ready_o for exactly one cycle, then return to IDLE.
REQ-021 Latency: ready_o SHALL be high exactly WIDTH+2 cycles after the accepting cycle.
REQ-022 Division SHALL truncate toward zero; quotient in lo_o, remainder in hi_o; remainder sign SHALL follow the dividend.
REQ-023 Signed most-negative / -1 SHALL yield lo_o = most-negative value (wrap) and hi_o = 0.
REQ-024 Divisor zero (div or divu) SHALL go directly IDLE->DONE: lo_o = all ones, hi_o = opa_i, divzero_o = 1; ready_o one cycle after acceptance.
REQ-025 annul_i=1 in any non-IDLE state SHALL force IDLE on the next edge, with no ready_o pulse and hi_o/lo_o unchanged.
REQ-026 annul_i=1 in DONE SHALL suppress nothing: ready_o is already registered high for that cycle; next state is IDLE.
REQ-027 start_i while busy_o=1 SHALL be ignored; start_i with annul_i in IDLE SHALL be ignored.
REQ-028 A new start_i SHALL be accepted in the IDLE cycle immediately after DONE (back-to-back throughput = latency+1).

Reset
REQ-029 On rst=1: state IDLE, count 0, busy_o 0, ready_o 0, divzero_o 0, hi_o 0, lo_o 0, internal accumulators 0.
REQ-030 rst asserted mid-operation SHALL abort immediately with no ready_o pulse; operation after deassertion SHALL require a fresh start_i.

Configuration
REQ-031 Macro MULDIV_FAST_MUL_EN defined: mult/multu SHALL compute the full product combinationally and go IDLE->DONE, with ready_o one cycle after acceptance; MUL state is unused.
REQ-032 MULDIV_FAST_MUL_EN undefined: multiplication SHALL use the iterative MUL path with WIDTH+2 latency; division is identical in both builds.

Verification (WIDTH=32)
REQ-033 mult 0xFFFFFFFE x 0x00000003 -> hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFA, ready_o at cycle 34 (cycle 1 if MULDIV_FAST_MUL_EN).
REQ-034 divu 100 / 7 -> lo_o=14, hi_o=2; div -7 / 2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF; both ready_o at cycle 34.
REQ-035 div 0x80000000 / 0xFFFFFFFF -> lo_o=0x80000000, hi_o=0, divzero_o=0.
REQ-036 divu 0x1234 / 0 -> ready_o at cycle 1, divzero_o=1, lo_o=0xFFFFFFFF, hi_o=0x1234.
REQ-037 Start divu, annul_i at cycle 10 -> busy_o low at cycle 11, no ready_o, hi_o/lo_o keep prior values; repeat with rst at cycle 10 -> all outputs 0.
REQ-038 start_i held high continuously -> second start ignored while busy, accepted in the IDLE cycle after DONE; start_i+annul_i in IDLE -> busy_o stays 0.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// Request/response bundle for muldiv_unit.
//   start_i, op_i, opa_i, opb_i, annul_i : requester -> unit
//   busy_o, ready_o, hi_o, lo_o, divzero_o : unit -> requester
// Modports: master (requester side), slave (muldiv_unit side).
interface muldiv_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start_i;
  logic [1:0]       op_i;
  logic [WIDTH-1:0] opa_i;
  logic [WIDTH-1:0] opb_i;
  logic             annul_i;
  logic             busy_o;
  logic             ready_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;
  logic             divzero_o;

  modport master (
    output start_i, op_i, opa_i, opb_i, annul_i,
    input  busy_o, ready_o, hi_o, lo_o, divzero_o
  );

  modport slave (
    input  start_i, op_i, opa_i, opb_i, annul_i,
    output busy_o, ready_o, hi_o, lo_o, divzero_o
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit.
//   op 00 mult (signed), 01 multu, 10 div (signed), 11 divu.
//   Multiply: shift-add, one step per cycle; divide: restoring, one step per
//   cycle. Both work on magnitudes and fix the sign in a final FIX cycle, so
//   a result appears WIDTH+2 cycles after acceptance. Divide by zero
//   finishes one cycle after acceptance with lo=all ones, hi=dividend.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   bus        : muldiv_unit_if.slave request/response bundle
// Build option:
//   MULDIV_FAST_MUL_EN : multiplication done combinationally in one cycle
//                        (IDLE->DONE); division unchanged.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_unit_if.slave  bus
);

  localparam int unsigned CNT_W  = $clog2(WIDTH);
  localparam int unsigned PROD_W = 2 * WIDTH;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DIV,
    FIX,
    DONE
  } muldivState_t;

  muldivState_t state, nextState;
  logic [CNT_W-1:0] count, nextCount;

  // accHi: product high half / partial remainder
  // accLo: multiplier being consumed / dividend shifting into quotient
  // mcand: multiplicand or divisor magnitude
  logic [WIDTH-1:0] accHi, nextAccHi;
  logic [WIDTH-1:0] accLo, nextAccLo;
  logic [WIDTH-1:0] mcand, nextMcand;
  logic             isMul, nextIsMul;
  logic             negMain, nextNegMain;   // product or quotient negative
  logic             negRem, nextNegRem;     // remainder negative

  logic [WIDTH-1:0] hiQ, nextHi;
  logic [WIDTH-1:0] loQ, nextLo;
  logic             busyQ, readyQ, divzeroQ, nextDivzero;

  // Operand magnitudes for the signed ops.
  logic             signedOp, signA, signB;
  logic [WIDTH-1:0] magA, magB;
  assign signedOp = ~bus.op_i[0];
  assign signA    = signedOp & bus.opa_i[WIDTH-1];
  assign signB    = signedOp & bus.opb_i[WIDTH-1];
  assign magA     = signA ? WIDTH'(-bus.opa_i) : bus.opa_i;
  assign magB     = signB ? WIDTH'(-bus.opb_i) : bus.opb_i;

  // One shift-add step: add multiplicand into the high half, shift right.
  logic [WIDTH:0] mulSum;
  assign mulSum = {1'b0, accHi} + (accLo[0] ? {1'b0, mcand} : {(WIDTH + 1){1'b0}});

  // One restoring step: bring in the next dividend bit, trial subtract.
  logic [WIDTH:0] divShift, divDiff;
  assign divShift = {accHi, accLo[WIDTH-1]};
  assign divDiff  = divShift - {1'b0, mcand};

  // Sign-corrected results used in FIX.
  logic [PROD_W-1:0] prodFix;
  logic [WIDTH-1:0]  quoFix, remFix;
  assign prodFix = negMain ? PROD_W'(-{accHi, accLo}) : {accHi, accLo};
  assign quoFix  = negMain ? WIDTH'(-accLo) : accLo;
  assign remFix  = negRem  ? WIDTH'(-accHi) : accHi;

`ifdef MULDIV_FAST_MUL_EN
  // Low 2*WIDTH bits of the extended product are correct for both signednesses.
  logic [PROD_W-1:0] extA, extB, fastProd;
  assign extA     = {{WIDTH{signA}}, bus.opa_i};
  assign extB     = {{WIDTH{signB}}, bus.opb_i};
  assign fastProd = PROD_W'(extA * extB);
`endif

  // State and step counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= nextState;
      count <= nextCount;
    end
  end

  // Next-state and datapath next values.
  always_comb begin
    nextState   = state;
    nextCount   = count;
    nextAccHi   = accHi;
    nextAccLo   = accLo;
    nextMcand   = mcand;
    nextIsMul   = isMul;
    nextNegMain = negMain;
    nextNegRem  = negRem;
    nextHi      = hiQ;
    nextLo      = loQ;
    nextDivzero = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus.start_i && !bus.annul_i) begin
          nextCount   = '0;
          nextAccHi   = '0;
          nextIsMul   = ~bus.op_i[1];
          nextNegMain = signA ^ signB;
          nextNegRem  = signA;
          if (!bus.op_i[1]) begin
            nextAccLo = magB;
            nextMcand = magA;
`ifdef MULDIV_FAST_MUL_EN
            nextState = DONE;
            nextHi    = fastProd[PROD_W-1:WIDTH];
            nextLo    = fastProd[WIDTH-1:0];
`else
            nextState = MUL;
`endif
          end else begin
            nextAccLo = magA;
            nextMcand = magB;
            if (bus.opb_i == '0) begin
              nextState   = DONE;
              nextHi      = bus.opa_i;
              nextLo      = '1;
              nextDivzero = 1'b1;
            end else begin
              nextState = DIV;
            end
          end
        end
      end

      MUL: begin
        nextAccHi = mulSum[WIDTH:1];
        nextAccLo = {mulSum[0], accLo[WIDTH-1:1]};
        nextCount = count + CNT_W'(1);
        if (count == LAST_STEP) nextState = FIX;
      end

      DIV: begin
        // Sign bit of the trial difference clear means the subtract fits.
        if (!divDiff[WIDTH]) begin
          nextAccHi = divDiff[WIDTH-1:0];
          nextAccLo = {accLo[WIDTH-2:0], 1'b1};
        end else begin
          nextAccHi = divShift[WIDTH-1:0];
          nextAccLo = {accLo[WIDTH-2:0], 1'b0};
        end
        nextCount = count + CNT_W'(1);
        if (count == LAST_STEP) nextState = FIX;
      end

      FIX: begin
        nextState = DONE;
        if (isMul) begin
          nextHi = prodFix[PROD_W-1:WIDTH];
          nextLo = prodFix[WIDTH-1:0];
        end else begin
          nextHi = remFix;
          nextLo = quoFix;
        end
      end

      DONE: nextState = IDLE;

      default: nextState = IDLE;
    endcase

    // Abort: back to IDLE with results untouched and no completion.
    if (state != IDLE && bus.annul_i) begin
      nextState   = IDLE;
      nextHi      = hiQ;
      nextLo      = loQ;
      nextDivzero = 1'b0;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      accHi    <= '0;
      accLo    <= '0;
      mcand    <= '0;
      isMul    <= 1'b0;
      negMain  <= 1'b0;
      negRem   <= 1'b0;
      hiQ      <= '0;
      loQ      <= '0;
      busyQ    <= 1'b0;
      readyQ   <= 1'b0;
      divzeroQ <= 1'b0;
    end else begin
      accHi    <= nextAccHi;
      accLo    <= nextAccLo;
      mcand    <= nextMcand;
      isMul    <= nextIsMul;
      negMain  <= nextNegMain;
      negRem   <= nextNegRem;
      hiQ      <= nextHi;
      loQ      <= nextLo;
      busyQ    <= (nextState != IDLE);
      readyQ   <= (nextState == DONE);
      divzeroQ <= nextDivzero;
    end
  end

  assign bus.busy_o    = busyQ;
  assign bus.ready_o   = readyQ;
  assign bus.hi_o      = hiQ;
  assign bus.lo_o      = loQ;
  assign bus.divzero_o = divzeroQ;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (WIDTH=32): vector table plus sequences for
// annul, mid-operation reset, held start and start-with-annul.
module tb_muldiv_unit;

  localparam int unsigned W = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int LAT_MUL = 1;
`else
  localparam int LAT_MUL = 34;
`endif
  localparam int LAT_DIV = 34;
  localparam int LAT_DZ  = 1;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(W)) bus ();

  muldiv_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Issue one request; returns the cycle (after acceptance) where ready_o is seen.
  task automatic runOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat);
    bus.op_i    = op;
    bus.opa_i   = a;
    bus.opb_i   = b;
    bus.start_i = 1'b1;
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    lat = -1;
    for (int c = 1; c <= 60 && lat < 0; c++) begin
      @(negedge clk);
      if (bus.ready_o === 1'b1) lat = c;
    end
  endtask

  vec_t vecs[16];

  initial begin
    int lat;
    int r1, r2;
    logic sawReady, sawBusy, busy35, busy36;

    vecs[0]  = '{"mult_m2x3",     2'b00, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, LAT_MUL};
    vecs[1]  = '{"multu_big_x3",  2'b01, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA, 1'b0, LAT_MUL};
    vecs[2]  = '{"multu_max_sq",  2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, LAT_MUL};
    vecs[3]  = '{"mult_minneg_sq",2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, LAT_MUL};
    vecs[4]  = '{"mult_m1xm1",    2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, LAT_MUL};
    vecs[5]  = '{"mult_x0",       2'b00, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, LAT_MUL};
    vecs[6]  = '{"divu_100_7",    2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, LAT_DIV};
    vecs[7]  = '{"div_m7_2",      2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, LAT_DIV};
    vecs[8]  = '{"div_7_m2",      2'b10, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, LAT_DIV};
    vecs[9]  = '{"div_m7_m2",     2'b10, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 1'b0, LAT_DIV};
    vecs[10] = '{"div_minneg_m1", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, LAT_DIV};
    vecs[11] = '{"divu_8000_ffff",2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0, LAT_DIV};
    vecs[12] = '{"divu_by0",      2'b11, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b1, LAT_DZ};
    vecs[13] = '{"div_by0",       2'b10, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, LAT_DZ};
    vecs[14] = '{"divu_max_1",    2'b11, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0, LAT_DIV};
    vecs[15] = '{"divu_5_10",     2'b11, 32'd5,        32'd10,       32'd5,        32'd0,        1'b0, LAT_DIV};

    rst         = 1'b1;
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    bus.op_i    = 2'b00;
    bus.opa_i   = '0;
    bus.opb_i   = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_busy",    64'(bus.busy_o),    64'd0);
    check("reset_ready",   64'(bus.ready_o),   64'd0);
    check("reset_divzero", 64'(bus.divzero_o), 64'd0);
    check("reset_hi",      64'(bus.hi_o),      64'd0);
    check("reset_lo",      64'(bus.lo_o),      64'd0);

    // Vector table: latency, results, and the single-cycle ready pulse.
    for (int i = 0; i < 16; i++) begin
      runOp(vecs[i].op, vecs[i].a, vecs[i].b, lat);
      check({vecs[i].name, "_latency"}, 64'(lat), 64'(vecs[i].lat));
      check({vecs[i].name, "_hi"},      64'(bus.hi_o),      64'(vecs[i].hi));
      check({vecs[i].name, "_lo"},      64'(bus.lo_o),      64'(vecs[i].lo));
      check({vecs[i].name, "_divzero"}, 64'(bus.divzero_o), 64'(vecs[i].dz));
      @(negedge clk);
      check({vecs[i].name, "_ready_drop"}, 64'(bus.ready_o), 64'd0);
      check({vecs[i].name, "_idle"},       64'(bus.busy_o),  64'd0);
    end

    // Annul at cycle 10 of a divu: idle next cycle, no ready, results kept (5/0).
    bus.op_i = 2'b11; bus.opa_i = 32'd100; bus.opb_i = 32'd7; bus.start_i = 1'b1;
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    for (int c = 1; c <= 10; c++) @(negedge clk);
    check("annul_busy_c10", 64'(bus.busy_o), 64'd1);
    bus.annul_i = 1'b1;
    @(posedge clk);
    #1 bus.annul_i = 1'b0;
    @(negedge clk);
    check("annul_busy_c11", 64'(bus.busy_o), 64'd0);
    sawReady = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (bus.ready_o === 1'b1) sawReady = 1'b1;
      @(negedge clk);
    end
    check("annul_no_ready", 64'(sawReady), 64'd0);
    check("annul_hi_kept",  64'(bus.hi_o), 64'd5);
    check("annul_lo_kept",  64'(bus.lo_o), 64'd0);

    // Reset at cycle 10: everything clears, nothing resumes afterwards.
    bus.op_i = 2'b11; bus.opa_i = 32'd100; bus.opb_i = 32'd7; bus.start_i = 1'b1;
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    for (int c = 1; c <= 10; c++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_busy",    64'(bus.busy_o),    64'd0);
    check("rst_mid_ready",   64'(bus.ready_o),   64'd0);
    check("rst_mid_hi",      64'(bus.hi_o),      64'd0);
    check("rst_mid_lo",      64'(bus.lo_o),      64'd0);
    check("rst_mid_divzero", 64'(bus.divzero_o), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    sawReady = 1'b0;
    sawBusy  = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.ready_o === 1'b1) sawReady = 1'b1;
      if (bus.busy_o === 1'b1) sawBusy = 1'b1;
    end
    check("rst_no_resume_ready", 64'(sawReady), 64'd0);
    check("rst_no_resume_busy",  64'(sawBusy),  64'd0);

    // start_i held high: second request accepted in the IDLE cycle after DONE.
    bus.op_i = 2'b11; bus.opa_i = 32'd100; bus.opb_i = 32'd7; bus.start_i = 1'b1;
    @(posedge clk);
    r1 = -1; r2 = -1; busy35 = 1'bx; busy36 = 1'bx;
    for (int c = 1; c <= 69; c++) begin
      @(negedge clk);
      if (bus.ready_o === 1'b1) begin
        if (r1 < 0) r1 = c;
        else if (r2 < 0) r2 = c;
      end
      if (c == 35) busy35 = bus.busy_o;
      if (c == 36) busy36 = bus.busy_o;
    end
    bus.start_i = 1'b0;
    check("held_first_ready",  64'(r1), 64'd34);
    check("held_busy_c35",     64'(busy35), 64'd0);
    check("held_busy_c36",     64'(busy36), 64'd1);
    check("held_second_ready", 64'(r2), 64'd69);
    check("held_second_lo",    64'(bus.lo_o), 64'd14);
    check("held_second_hi",    64'(bus.hi_o), 64'd2);
    repeat (2) @(negedge clk);
    check("held_then_idle", 64'(bus.busy_o), 64'd0);

    // start_i with annul_i in IDLE is ignored.
    bus.op_i = 2'b11; bus.opa_i = 32'd9; bus.opb_i = 32'd0;
    bus.start_i = 1'b1; bus.annul_i = 1'b1;
    @(posedge clk);
    #1 begin bus.start_i = 1'b0; bus.annul_i = 1'b0; end
    sawReady = 1'b0;
    sawBusy  = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus.ready_o === 1'b1) sawReady = 1'b1;
      if (bus.busy_o === 1'b1) sawBusy = 1'b1;
    end
    check("start_annul_busy",  64'(sawBusy),  64'd0);
    check("start_annul_ready", 64'(sawReady), 64'd0);
    check("start_annul_hi",    64'(bus.hi_o), 64'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
